// File: rtl/xdiv_unsigned.sv
// xdiv_unsigned: iterative restoring divider, one quotient bit per clock.
// Fixed latency of BWID_N+1 clocks from the accepting edge, independent of operands.
// A zero divisor takes the same path and raises oDivZero alongside the result.
module xdiv_unsigned #(
  parameter int BWID_N = 16,
  parameter int BWID_D = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [BWID_N-1:0] iN,
  input  logic [BWID_D-1:0] iD,
  output logic              oValid,
  output logic [BWID_N-1:0] oQ,
  output logic [BWID_D-1:0] oR,
  output logic              oDivZero
);

  localparam int CW = $clog2(BWID_N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [BWID_N-1:0] dvd;
  logic [BWID_D-1:0] dvs;
  logic [BWID_D:0]   rem;
  logic [CW-1:0]     cnt;
  logic              div_zero;

  logic [BWID_D:0]   shifted;
  logic [BWID_D+1:0] trial;
  logic              borrow;

  // The partial remainder keeps its classic extra top bit, but only the
  // low BWID_D bits feed the next shift; the msb is never needed again.
  logic              unused_rem_msb;
  assign unused_rem_msb = rem[BWID_D];

  assign oReady = (state == S_IDLE);

  // One restoring step: shift in the next dividend bit and try subtracting the divisor.
  always_comb begin
    shifted = {rem[BWID_D-1:0], dvd[BWID_N-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    borrow  = trial[BWID_D+1];
  end

  // Control FSM and working registers; results are registered only when leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
      oValid   <= 1'b0;
      oQ       <= '0;
      oR       <= '0;
      oDivZero <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iValid) begin
            dvd      <= iN;
            dvs      <= iD;
            rem      <= '0;
            cnt      <= '0;
            div_zero <= (iD == '0);
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          rem <= borrow ? shifted : trial[BWID_D:0];
          dvd <= {dvd[BWID_N-2:0], ~borrow};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BWID_N-1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          oQ       <= dvd;
          oR       <= rem[BWID_D-1:0];
          oDivZero <= div_zero;
          oValid   <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xdiv_unsigned.sv
// Self-checking bench for xdiv_unsigned (BWID_N=16, BWID_D=8).
// Expected results come from plain integer division in a reference function.
module tb_xdiv_unsigned;

  localparam int N = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [N-1:0] i_n;
  logic [D-1:0] i_d;
  logic         o_ready;
  logic         o_valid;
  logic [N-1:0] o_q;
  logic [D-1:0] o_r;
  logic         o_dz;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  xdiv_unsigned #(.BWID_N(N), .BWID_D(D)) dut (
    .clk(clk), .rst(rst), .iValid(i_valid), .oReady(o_ready),
    .iN(i_n), .iD(i_d), .oValid(o_valid), .oQ(o_q), .oR(o_r), .oDivZero(o_dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: quotient/remainder by plain arithmetic; zero divisor gives all ones and the low dividend bits.
  function automatic void ref_div(input logic [N-1:0] n, input logic [D-1:0] d,
                                  output logic [N-1:0] q, output logic [D-1:0] r);
    int unsigned ni, di;
    ni = n;
    di = d;
    if (di == 0) begin
      q = '1;
      r = n[D-1:0];
    end else begin
      q = N'(ni / di);
      r = D'(ni % di);
    end
  endfunction

  // Drive one request and wait for its result; reports latency from the accepting edge.
  task automatic run_op(input logic [N-1:0] n, input logic [D-1:0] d,
                        output logic [N-1:0] q, output logic [D-1:0] r, output logic dz,
                        output int lat, output logic to);
    int w;
    w   = 0;
    to  = 1'b0;
    lat = 0;
    q   = '0;
    r   = '0;
    dz  = 1'b0;
    @(negedge clk);
    while (!o_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      to = 1'b1;
      return;
    end
    i_n = n;
    i_d = d;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_n = N'($urandom);
    i_d = D'($urandom);
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (o_valid) break;
    end
    if (!o_valid) to = 1'b1;
    q  = o_q;
    r  = o_r;
    dz = o_dz;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 1'b1;
    i_n = 16'd100;
    i_d = 8'd3;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_during got=%b exp=1", o_ready); end
    end
    rst = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", o_valid); end
    checks++;
    if (o_q !== '0) begin failures++; $display("[TB] FAIL reset_q got=%0d exp=0", o_q); end
    checks++;
    if (o_r !== '0) begin failures++; $display("[TB] FAIL reset_r got=%0d exp=0", o_r); end
    checks++;
    if (o_dz !== 1'b0) begin failures++; $display("[TB] FAIL reset_divzero got=%b exp=0", o_dz); end
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_basic();
    logic [N-1:0] q;
    logic [D-1:0] r;
    logic dz, to;
    int lat;
    run_op(16'd1000, 8'd7, q, r, dz, lat, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("[TB] FAIL basic_timeout got=%b exp=0", to); end
    checks++;
    if (q !== 16'd142) begin failures++; $display("[TB] FAIL basic_q got=%0d exp=142", q); end
    checks++;
    if (r !== 8'd6) begin failures++; $display("[TB] FAIL basic_r got=%0d exp=6", r); end
    checks++;
    if (dz !== 1'b0) begin failures++; $display("[TB] FAIL basic_divzero got=%b exp=0", dz); end
    checks++;
    if (lat != 17) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=17", lat); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse_width got=%b exp=0", o_valid); end
    checks++;
    if (o_q !== 16'd142) begin failures++; $display("[TB] FAIL basic_q_held got=%0d exp=142", o_q); end
  endtask

  task automatic test_extremes();
    logic [N-1:0] tn [3] = '{16'd65535, 16'd5, 16'd65535};
    logic [D-1:0] td [3] = '{8'd1, 8'd9, 8'd255};
    logic [N-1:0] eq [3] = '{16'd65535, 16'd0, 16'd257};
    logic [D-1:0] er [3] = '{8'd0, 8'd5, 8'd0};
    logic [N-1:0] q;
    logic [D-1:0] r;
    logic dz, to;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(tn[i], td[i], q, r, dz, lat, to);
      checks++;
      if (to !== 1'b0) begin failures++; $display("[TB] FAIL extreme%0d_timeout got=%b exp=0", i, to); end
      checks++;
      if (q !== eq[i]) begin failures++; $display("[TB] FAIL extreme%0d_q got=%0d exp=%0d", i, q, eq[i]); end
      checks++;
      if (r !== er[i]) begin failures++; $display("[TB] FAIL extreme%0d_r got=%0d exp=%0d", i, r, er[i]); end
      checks++;
      if (dz !== 1'b0) begin failures++; $display("[TB] FAIL extreme%0d_divzero got=%b exp=0", i, dz); end
    end
  endtask

  task automatic test_divzero();
    logic [N-1:0] q;
    logic [D-1:0] r;
    logic dz, to;
    int lat;
    run_op(16'd1234, 8'd0, q, r, dz, lat, to);
    checks++;
    if (to !== 1'b0) begin failures++; $display("[TB] FAIL divzero_timeout got=%b exp=0", to); end
    checks++;
    if (q !== 16'hFFFF) begin failures++; $display("[TB] FAIL divzero_q got=%h exp=ffff", q); end
    checks++;
    if (r !== 8'hD2) begin failures++; $display("[TB] FAIL divzero_r got=%h exp=d2", r); end
    checks++;
    if (dz !== 1'b1) begin failures++; $display("[TB] FAIL divzero_flag got=%b exp=1", dz); end
    checks++;
    if (lat != 17) begin failures++; $display("[TB] FAIL divzero_latency got=%0d exp=17", lat); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] pn [3] = '{16'd50000, 16'd777, 16'd65000};
    logic [D-1:0] pd [3] = '{8'd3, 8'd200, 8'd255};
    logic [N-1:0] rq [3];
    logic [D-1:0] rr [3];
    int acc [3];
    int rc [3];
    int idx, nres;
    logic [N-1:0] eq;
    logic [D-1:0] er;
    idx = 0;
    nres = 0;
    for (int t = 0; t < 120 && nres < 3; t++) begin
      @(negedge clk);
      if (o_valid) begin
        rq[nres] = o_q;
        rr[nres] = o_r;
        rc[nres] = cyc;
        nres++;
      end
      if (o_ready) begin
        if (idx < 3) begin
          i_n = pn[idx];
          i_d = pd[idx];
          i_valid = 1'b1;
          acc[idx] = cyc;
          idx++;
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    i_valid = 1'b0;
    checks++;
    if (nres != 3) begin failures++; $display("[TB] FAIL b2b_result_count got=%0d exp=3", nres); end
    else begin
      for (int i = 0; i < 3; i++) begin
        ref_div(pn[i], pd[i], eq, er);
        checks++;
        if (rq[i] !== eq) begin failures++; $display("[TB] FAIL b2b%0d_q got=%0d exp=%0d", i, rq[i], eq); end
        checks++;
        if (rr[i] !== er) begin failures++; $display("[TB] FAIL b2b%0d_r got=%0d exp=%0d", i, rr[i], er); end
        checks++;
        if (rc[i] - acc[i] != 18) begin failures++; $display("[TB] FAIL b2b%0d_latency got=%0d exp=18", i, rc[i] - acc[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] != 18) begin failures++; $display("[TB] FAIL b2b%0d_accept_gap got=%0d exp=18", i, acc[i] - acc[i-1]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] q, eq;
    logic [D-1:0] r, er;
    logic dz, to;
    int lat, w;
    w = 0;
    @(negedge clk);
    while (!o_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    i_n = 16'd40000;
    i_d = 8'd13;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready got=%b exp=1", o_ready); end
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%b exp=0", o_valid); end
    checks++;
    if (o_q !== '0) begin failures++; $display("[TB] FAIL midrst_q got=%0d exp=0", o_q); end
    checks++;
    if (o_r !== '0) begin failures++; $display("[TB] FAIL midrst_r got=%0d exp=0", o_r); end
    checks++;
    if (o_dz !== 1'b0) begin failures++; $display("[TB] FAIL midrst_divzero got=%b exp=0", o_dz); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid_late got=%b exp=0", o_valid); end
    run_op(16'd60001, 8'd97, q, r, dz, lat, to);
    ref_div(16'd60001, 8'd97, eq, er);
    checks++;
    if (to !== 1'b0) begin failures++; $display("[TB] FAIL midrst_next_timeout got=%b exp=0", to); end
    checks++;
    if (lat != 17) begin failures++; $display("[TB] FAIL midrst_next_latency got=%0d exp=17", lat); end
    checks++;
    if (q !== eq) begin failures++; $display("[TB] FAIL midrst_next_q got=%0d exp=%0d", q, eq); end
    checks++;
    if (r !== er) begin failures++; $display("[TB] FAIL midrst_next_r got=%0d exp=%0d", r, er); end
  endtask

  task automatic test_random();
    logic [N-1:0] n, q, eq;
    logic [D-1:0] d, r, er;
    logic dz, to;
    int lat;
    int unsigned recon;
    for (int i = 0; i < 2000; i++) begin
      n = N'($urandom);
      d = D'($urandom_range(1, 255));
      run_op(n, d, q, r, dz, lat, to);
      ref_div(n, d, eq, er);
      recon = int'(q) * int'(d) + int'(r);
      checks++;
      if (to !== 1'b0) begin failures++; $display("[TB] FAIL rand_timeout n=%0d d=%0d", n, d); end
      checks++;
      if (q !== eq || r !== er) begin
        failures++;
        $display("[TB] FAIL rand_qr n=%0d d=%0d got q=%0d r=%0d exp q=%0d r=%0d", n, d, q, r, eq, er);
      end
      checks++;
      if (recon != int'(n) || r >= d) begin
        failures++;
        $display("[TB] FAIL rand_identity n=%0d d=%0d got q*d+r=%0d r=%0d exp n=%0d r<d", n, d, recon, r, n);
      end
      checks++;
      if (lat != 17 || dz !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rand_latency_flag got lat=%0d dz=%b exp lat=17 dz=0", lat, dz);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_n = '0;
    i_d = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_divzero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
